// File: rtl/mmio_uart_tx_pkg.sv
// ============================================================================
// Module   : mmio_uart_tx_pkg
// Brief    : Register map, STATUS bit positions and TX FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_uart_tx_pkg;

    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 8;

`ifdef UART_TX_PARITY_EN
    localparam int STATE_W = 3;
`else
    localparam int STATE_W = 2;
`endif

    localparam logic [STATE_W-1:0] S_IDLE   = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_START  = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_DATA   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_STOP   = STATE_W'(3);
`ifdef UART_TX_PARITY_EN
    localparam logic [STATE_W-1:0] S_PARITY = STATE_W'(4);
`endif

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_uart_tx_sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO; push on full is
//            accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/mmio_uart_tx.sv
// ============================================================================
// Module   : mmio_uart_tx
// Brief    : Memory-mapped buffered UART transmitter (8N1) on the data port.
// Options  : define UART_TX_PARITY_EN to insert an even parity bit (8E1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        sel,
    output logic [31:0] read_data,
    output logic        txd
);

    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [7:0]         fifo_dout;
    logic [CNT_W-1:0]   fifo_count;
    logic               wr_txdata;
    logic               wr_status;
    logic [31:0]        status;
    logic               bit_end;
    logic               w_unused;

    logic               ovf_q,   ovf_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [15:0]        baud_q,  baud_d;
    logic [2:0]         bit_q,   bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               txd_q,   txd_d;

    assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
    assign wr_txdata = memwrite && sel && (addr[2] == REG_TXDATA[2]);
    assign wr_status = memwrite && sel && (addr[2] == REG_STATUS[2]);
    assign fifo_push = wr_txdata;
    assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty;
    assign w_unused  = ^{addr[1:0], write_data[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Set is evaluated last so it wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_status && write_data[ST_OVF]) ovf_d = 1'b0;
        if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    end

    always_comb begin
        status                    = '0;
        status[ST_FULL]           = fifo_full;
        status[ST_EMPTY]          = fifo_empty;
        status[ST_BUSY]           = (state_q != S_IDLE);
        status[ST_OVF]            = ovf_q;
        status[ST_COUNT +: CNT_W] = fifo_count;
        read_data                 = '0;
        if (sel && (addr[2] == REG_STATUS[2])) read_data = status;
    end

`ifdef UART_TX_PARITY_EN
    logic parity_q, parity_d;
`endif

    // txd_d is the line level for the state being entered, keeping txd registered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        bit_end = (baud_q == BAUD_LAST);
        if (state_q != S_IDLE) baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_START;
                    shift_d = fifo_dout;
                    baud_d  = 16'd0;
                    txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_dout);
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign txd = txd_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// ============================================================================
// Module   : tb_mmio_uart_tx
// Brief    : Scoreboard bench for mmio_uart_tx (CLK_DIV=4, FIFO_DEPTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DIV   = 4;
    localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS = 11;
`else
    localparam int          NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        sel;
    logic [31:0] read_data;
    logic        txd;

    int          n_checks   = 0;
    int          n_errors   = 0;
    logic [7:0]  exp_q[$];
    bit          mon_active = 1'b0;
    int          mon_frames = 0;

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .addr       (addr),
        .write_data (write_data),
        .sel        (sel),
        .read_data  (read_data),
        .txd        (txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite   = 1'b1;
        addr       = a;
        write_data = d;
        step(1);
        memwrite   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = read_data;
    endtask

    function automatic logic [31:0] status_word(input logic full, input logic empty,
                                                input logic busy, input logic ovf,
                                                input int count);
        logic [31:0] w;
        w = 32'(count) << 8;
        w = w | {28'd0, ovf, busy, empty, full};
        return w;
    endfunction

    // Line level of UART bit slot j for byte b: start, 8 data LSB first, [parity], stop.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (j == 9 && NBITS == 11) return ^b;
        return 1'b1;
    endfunction

    task automatic drain();
        int budget;
        budget = 20000;
        while ((exp_q.size() != 0 || mon_active) && budget > 0) begin
            step(1);
            budget--;
        end
        chk("drain_done_in_budget", 32'(budget > 0), 32'd1);
        step(DIV + 2);
    endtask

    // Monitor: recovers frames from txd by mid-bit sampling and scores them.
    initial begin : monitor
        int          cnt;
        int          j;
        logic [10:0] bits;
        logic [7:0]  data;
        cnt  = 0;
        bits = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (txd === 1'b0) begin
                    mon_active = 1'b1;
                    cnt        = 0;
                end
            end else begin
                cnt++;
            end
            if (mon_active && (cnt % DIV) == DIV / 2) begin
                j       = cnt / DIV;
                bits[j] = txd;
                if (j == NBITS - 1) begin
                    mon_active = 1'b0;
                    mon_frames++;
                    data = bits[8:1];
                    chk("rx_start_bit", 32'(bits[0]), 32'd0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rx_unexpected_frame actual=%h required=none", data);
                    end else begin
                        chk("rx_byte", 32'(data), 32'(exp_q.pop_front()));
                    end
                    if (NBITS == 11) chk("rx_parity", 32'(bits[9]), 32'(^data));
                    chk("rx_stop_bit", 32'(bits[NBITS-1]), 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] d;
        logic [7:0]  b;
        int          n;
        int          acc;
        int          exp_cnt;
        int          frames_before;
        int          lows;

        reset      = 1'b1;
        memwrite   = 1'b0;
        addr       = '0;
        write_data = '0;
        step(2);
        reset = 1'b0;

        // Reset state
        chk("t1_txd_idle", 32'(txd), 32'd1);
        rd(BASE + 32'd4, d);
        chk("t1_status", d, status_word(1'b0, 1'b1, 1'b0, 1'b0, 0));
        rd(BASE, d);
        chk("t1_txdata_read", d, 32'd0);
        chk("t1_sel_base", 32'(sel), 32'd1);

        // Single frame, cycle-exact waveform and busy window
        exp_q.push_back(8'h55);
        wr(BASE, 32'h55);
        chk("t2_txd_before_start", 32'(txd), 32'd1);
        addr = BASE + 32'd4;
        for (int k = 0; k < NBITS * DIV; k++) begin
            step(1);
            chk("t2_txd_wave", 32'(txd), 32'(frame_bit(8'h55, k / DIV)));
            chk("t2_busy", 32'(read_data[2]), 32'd1);
        end
        step(1);
        chk("t2_status_after", read_data, status_word(1'b0, 1'b1, 1'b0, 1'b0, 0));

        // Overflow burst from idle: DEPTH+1 accepted, rest dropped
        for (int i = 0; i < 10; i++) begin
            if (i < DEPTH + 1) exp_q.push_back(8'h30 + 8'(i));
            wr(BASE, 32'h30 + 32'(i));
        end
        rd(BASE + 32'd4, d);
        chk("t3_status_full_ovf", d, status_word(1'b1, 1'b0, 1'b1, 1'b1, DEPTH));
        wr(BASE + 32'd4, 32'h8);
        rd(BASE + 32'd4, d);
        chk("t4_status_ovf_clear", d, status_word(1'b1, 1'b0, 1'b1, 1'b0, DEPTH));
        drain();
        rd(BASE + 32'd4, d);
        chk("t4_status_drained", d, status_word(1'b0, 1'b1, 1'b0, 1'b0, 0));

        // Random bursts from idle
        for (int r = 0; r < 6; r++) begin
            n   = $urandom_range(1, DEPTH + 3);
            acc = (n > DEPTH + 1) ? DEPTH + 1 : n;
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                if (i < DEPTH + 1) exp_q.push_back(b);
                wr(BASE, {$urandom} & 32'hFFFF_FF00 | 32'(b));
            end
            exp_cnt = (n == 1) ? 1 : acc - 1;
            rd(BASE + 32'd4, d);
            chk("rnd_overflow", 32'(d[3]), 32'(n > DEPTH + 1));
            chk("rnd_count", 32'(d[15:8]), 32'(exp_cnt));
            wr(BASE + 32'd4, 32'h8);
            rd(BASE + 32'd4, d);
            chk("rnd_ovf_cleared", 32'(d[3]), 32'd0);
            drain();
            rd(BASE + 32'd4, d);
            chk("rnd_status_idle", d, status_word(1'b0, 1'b1, 1'b0, 1'b0, 0));
        end

        // Reset 15 cycles into a frame with 3 bytes queued
        for (int i = 0; i < 4; i++) wr(BASE, 32'($urandom_range(0, 255)));
        step(13);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t5_txd_after_reset", 32'(txd), 32'd1);
        rd(BASE + 32'd4, d);
        chk("t5_status_after_reset", d, status_word(1'b0, 1'b1, 1'b0, 1'b0, 0));
        frames_before = mon_frames;
        lows = 0;
        for (int k = 0; k < 150; k++) begin
            step(1);
            if (txd !== 1'b1) lows++;
        end
        chk("t5_txd_low_cycles", 32'(lows), 32'd0);
        chk("t5_no_frames", 32'(mon_frames), 32'(frames_before));

        // Out-of-window accesses
        rd(BASE + 32'd8, d);
        chk("t6_sel_base8", 32'(sel), 32'd0);
        chk("t6_read_base8", d, 32'd0);
        wr(BASE + 32'd8, 32'hAA);
        rd(32'h1000_0010, d);
        chk("t6_sel_0x10", 32'(sel), 32'd0);
        chk("t6_read_0x10", d, 32'd0);
        wr(32'h1000_0010, 32'hAA);
        rd(BASE + 32'd4, d);
        chk("t6_status", d, status_word(1'b0, 1'b1, 1'b0, 1'b0, 0));
        lows = 0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (txd !== 1'b1) lows++;
        end
        chk("t6_txd_low_cycles", 32'(lows), 32'd0);

        chk("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
